flash_arbiter: RTL and testbench
================================

Name: flash_arbiter

Overview:
- Two-master arbiter and sequencer for the single flash bus slave port (addr/data/select/we/ack).
- Master 0 is the CPU data-side bus; master 1 is the instruction-fetch/boot side.
- Registers each accepted request and holds it stable on the slave port until the flash slave acks.
- Returns the result to the winning master as a one-cycle ack, using round-robin arbitration and a watchdog timeout.

Parameters:
- ADDR_W, 32, bus address width
- DATA_W, 32, bus data width
- TIMEOUT, 255, max cycles in BUSY waiting for slave ack before error completion (≥2)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous active-low reset
- m0_addr_i  in  ADDR_W  master 0 address
- m0_data_i  in  DATA_W  master 0 write data
- m0_select_i  in  1  master 0 request, held until m0_ack_o
- m0_we_i  in  1  master 0 write enable
- m0_data_o  out  DATA_W  read data to master 0
- m0_ack_o  out  1  one-cycle completion to master 0
- m0_err_o  out  1  timeout flag, valid with m0_ack_o
- m1_addr_i, m1_data_i, m1_select_i, m1_we_i, m1_data_o, m1_ack_o, m1_err_o: same as master 0, for master 1
- s_addr_o  out  ADDR_W  address to flash slave
- s_data_o  out  DATA_W  write data to flash slave
- s_select_o  out  1  slave request
- s_we_o  out  1  slave write enable
- s_data_i  in  DATA_W  slave read data
- s_ack_i  in  1  slave completion

Behaviour:
- Reset (rst=0, async): state IDLE, last_grant=1 (so master 0 wins the first tie).
- All outputs 0 during reset: s_* outputs, mN_ack_o, mN_err_o, mN_data_o, timeout counter.
- States: IDLE, BUSY, DONE. All outputs are registered.
- IDLE:
  - If any select is high, pick the winner: the sole requester; on a tie, the master that is not last_grant.
  - Latch the winner's addr/data/we into the s_* registers and set s_select_o=1.
  - Record grant (the winner's index) and last_grant=winner; clear counter; go to BUSY.
  - No request: stay in IDLE with s_select_o=0.
- BUSY:
  - s_addr_o, s_data_o, s_we_o and s_select_o are held constant.
  - Master inputs are ignored; changes after acceptance have no effect.
  - On s_ack_i=1: capture s_data_i into mG_data_o (G = grant, for both read and write), pulse mG_ack_o, clear s_select_o, go to DONE.
  - Counter increments each cycle with no ack. On reaching TIMEOUT-1 with no ack: mG_data_o=0, mG_err_o=1, mG_ack_o=1, s_select_o=0, go to DONE.
  - s_ack_i in the same cycle the counter hits TIMEOUT-1 is a normal completion with err=0.
- DONE: ack and err are low again (both are exactly one-cycle pulses). s_ack_i is ignored; a lingering slave ack is harmless. Go to IDLE.
- Latency:
  - Request seen in IDLE at edge N gives s_select_o high from N+1.
  - s_ack_i sampled at edge K gives mG_ack_o high for the cycle after K.
  - The earliest next grant is 2 cycles after ack, which is the turnaround that lets the served master drop select.
- mN_data_o keeps its last value until the next completion to that master.
- The non-granted master's ack/err stay 0 throughout.
- A master that drops select while BUSY still receives its ack; no abort.
- Reset mid-transaction: immediate return to IDLE, outputs cleared; no ack is issued for the lost transaction.

Test Plan:
- Single read, m0 addr=0x0000_0010, slave acks 3 cycles after select with data 0x0000_BEEF → s_addr_o=0x10, s_we_o=0, m0_ack_o one cycle, m0_data_o=0x0000_BEEF, m1_ack_o stays 0.
- Simultaneous requests on consecutive transactions (masters re-request immediately after ack) → grant order m0, m1, m0, m1. Each slave transaction shows the correct master's addr/we; s_select_o drops for ≥1 cycle between transactions.
- m1 write addr=0x24 data=0x1234 with m1 inputs changed to 0xFFFF one cycle after grant → s_data_o stays 0x1234 until ack, m1_ack_o=1, m1_err_o=0.
- TIMEOUT=8, s_ack_i held 0 → m0_ack_o and m0_err_o high together exactly 8 cycles after s_select_o rises; m0_data_o=0; a following m1 request is served normally.
- Slave ack held high for 4 cycles → exactly one m0_ack_o pulse; the next request is not falsely completed by the stale ack in DONE/IDLE.
- rst pulled low while BUSY → all outputs 0 asynchronously, no ack issued; after release a tie between m0 and m1 goes to m0.

Source files
------------

// File: rtl/flash_arbiter.sv
// Two-master round-robin arbiter/sequencer in front of a single flash slave port.
// Each accepted request is registered and held on the slave port until ack or watchdog timeout.
module flash_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_data_i,
    input  logic              m0_select_i,
    input  logic              m0_we_i,
    output logic [DATA_W-1:0] m0_data_o,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_data_i,
    input  logic              m1_select_i,
    input  logic              m1_we_i,
    output logic [DATA_W-1:0] m1_data_o,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    output logic [ADDR_W-1:0] s_addr_o,
    output logic [DATA_W-1:0] s_data_o,
    output logic              s_select_o,
    output logic              s_we_o,
    input  logic [DATA_W-1:0] s_data_i,
    input  logic              s_ack_i,
    output logic [1:0]        dbg_state
);

    // Handshake: a master holds select (and its addr/data/we) until it sees a
    // one-cycle ack; the slave side holds s_select_o until s_ack_i is sampled high.

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               grant_q, grant_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  s_addr_d;
    logic [DATA_W-1:0]  s_data_d;
    logic               s_select_d, s_we_d;
    logic [DATA_W-1:0]  m0_data_d, m1_data_d;
    logic               m0_ack_d, m0_err_d, m1_ack_d, m1_err_d;
    logic               win;

    assign dbg_state = state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            grant_q    <= 1'b0;
            last_q     <= 1'b1;
            cnt_q      <= '0;
            s_addr_o   <= '0;
            s_data_o   <= '0;
            s_select_o <= 1'b0;
            s_we_o     <= 1'b0;
            m0_data_o  <= '0;
            m0_ack_o   <= 1'b0;
            m0_err_o   <= 1'b0;
            m1_data_o  <= '0;
            m1_ack_o   <= 1'b0;
            m1_err_o   <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            s_addr_o   <= s_addr_d;
            s_data_o   <= s_data_d;
            s_select_o <= s_select_d;
            s_we_o     <= s_we_d;
            m0_data_o  <= m0_data_d;
            m0_ack_o   <= m0_ack_d;
            m0_err_o   <= m0_err_d;
            m1_data_o  <= m1_data_d;
            m1_ack_o   <= m1_ack_d;
            m1_err_o   <= m1_err_d;
        end
    end

    // Sole requester wins; a tie goes to the master that was not served last.
    assign win = (m0_select_i && m1_select_i) ? ~last_q : m1_select_i;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        s_addr_d   = s_addr_o;
        s_data_d   = s_data_o;
        s_select_d = s_select_o;
        s_we_d     = s_we_o;
        m0_data_d  = m0_data_o;
        m1_data_d  = m1_data_o;
        m0_ack_d   = 1'b0;
        m0_err_d   = 1'b0;
        m1_ack_d   = 1'b0;
        m1_err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                s_select_d = 1'b0;
                if (m0_select_i || m1_select_i) begin
                    s_addr_d   = win ? m1_addr_i : m0_addr_i;
                    s_data_d   = win ? m1_data_i : m0_data_i;
                    s_we_d     = win ? m1_we_i   : m0_we_i;
                    s_select_d = 1'b1;
                    grant_d    = win;
                    last_d     = win;
                    cnt_d      = '0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                // A slave ack always beats the watchdog, even on the last count.
                if (s_ack_i || (cnt_q == CNT_LAST)) begin
                    s_select_d = 1'b0;
                    state_d    = DONE;
                    if (grant_q) begin
                        m1_data_d = s_ack_i ? s_data_i : '0;
                        m1_ack_d  = 1'b1;
                        m1_err_d  = ~s_ack_i;
                    end else begin
                        m0_data_d = s_ack_i ? s_data_i : '0;
                        m0_ack_d  = 1'b1;
                        m0_err_d  = ~s_ack_i;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_flash_arbiter.sv
// Directed bench for flash_arbiter: reset, single read, round robin, write hold,
// watchdog timeout, stale slave ack and reset during a transaction.
module tb_flash_arbiter;

    logic        clk;
    logic        rst;
    logic [31:0] m0_addr_i, m0_data_i, m0_data_o;
    logic        m0_select_i, m0_we_i, m0_ack_o, m0_err_o;
    logic [31:0] m1_addr_i, m1_data_i, m1_data_o;
    logic        m1_select_i, m1_we_i, m1_ack_o, m1_err_o;
    logic [31:0] s_addr_o, s_data_o, s_data_i;
    logic        s_select_o, s_we_o, s_ack_i;
    logic [1:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;

    flash_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_select_i(m0_select_i),
        .m0_we_i(m0_we_i), .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_select_i(m1_select_i),
        .m1_we_i(m1_we_i), .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_select_o(s_select_o), .s_we_o(s_we_o),
        .s_data_i(s_data_i), .s_ack_i(s_ack_i), .dbg_state(dbg_state)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Driver tasks: inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_select(output bit ok);
        for (int k = 0; k < 10 && !s_select_o; k++) tick();
        ok = s_select_o;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        m0_addr_i = '0; m0_data_i = '0; m0_select_i = 0; m0_we_i = 0;
        m1_addr_i = '0; m1_data_i = '0; m1_select_i = 0; m1_we_i = 0;
        s_data_i = '0; s_ack_i = 0;
        tick();
        n_vec++; if ({s_select_o, s_we_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o} !== 6'b0) begin n_err++; $display("FAIL rst_ctl: got %b want 000000", {s_select_o, s_we_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}); end
        n_vec++; if ({s_addr_o, s_data_o, m0_data_o, m1_data_o} !== 128'b0) begin n_err++; $display("FAIL rst_data: got %h want 0", {s_addr_o, s_data_o, m0_data_o, m1_data_o}); end
        rst = 1'b1;
        tick();
        n_vec++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_addr;
        logic        exp_we;
        bit          ok;
        m0_addr_i = 32'h100; m0_we_i = 0; m0_data_i = 32'h11;
        m1_addr_i = 32'h200; m1_we_i = 1; m1_data_i = 32'h22;
        m0_select_i = 1; m1_select_i = 1;
        for (int i = 0; i < 4; i++) begin
            exp_addr = (i % 2 == 0) ? 32'h100 : 32'h200;
            exp_we   = (i % 2 == 1);
            wait_select(ok);
            n_vec++; if (!ok) begin n_err++; $display("FAIL rr_select[%0d]: got 0 want 1", i); end
            n_vec++; if (s_addr_o !== exp_addr || s_we_o !== exp_we) begin n_err++; $display("FAIL rr_grant[%0d]: got addr %h we %b want addr %h we %b", i, s_addr_o, s_we_o, exp_addr, exp_we); end
            s_ack_i = 1; s_data_i = 32'hA000 + i;
            tick();
            s_ack_i = 0;
            n_vec++; if ((i % 2 == 0) ? (m0_ack_o !== 1 || m1_ack_o !== 0 || m0_data_o !== 32'hA000 + i)
                                      : (m1_ack_o !== 1 || m0_ack_o !== 0 || m1_data_o !== 32'hA000 + i)) begin
                n_err++; $display("FAIL rr_ack[%0d]: got ack0 %b ack1 %b d0 %h d1 %h", i, m0_ack_o, m1_ack_o, m0_data_o, m1_data_o);
            end
            if (i == 3) begin m0_select_i = 0; m1_select_i = 0; end
            tick();
            n_vec++; if (s_select_o !== 0) begin n_err++; $display("FAIL rr_gap[%0d]: got %b want 0", i, s_select_o); end
        end
        tick();
    endtask

    task automatic test_single_read();
        m0_addr_i = 32'h10; m0_we_i = 0; m0_select_i = 1;
        tick();
        n_vec++; if (s_select_o !== 1 || s_addr_o !== 32'h10 || s_we_o !== 0) begin n_err++; $display("FAIL rd_req: got sel %b addr %h we %b want 1 10 0", s_select_o, s_addr_o, s_we_o); end
        tick(); tick();
        s_ack_i = 1; s_data_i = 32'hBEEF;
        tick();
        n_vec++; if (m0_ack_o !== 1 || m0_data_o !== 32'hBEEF || m0_err_o !== 0) begin n_err++; $display("FAIL rd_ack: got ack %b data %h err %b want 1 beef 0", m0_ack_o, m0_data_o, m0_err_o); end
        n_vec++; if (m1_ack_o !== 0 || s_select_o !== 0) begin n_err++; $display("FAIL rd_other: got ack1 %b sel %b want 0 0", m1_ack_o, s_select_o); end
        s_ack_i = 0; m0_select_i = 0;
        tick();
        n_vec++; if (m0_ack_o !== 0 || m0_data_o !== 32'hBEEF) begin n_err++; $display("FAIL rd_pulse: got ack %b data %h want 0 beef", m0_ack_o, m0_data_o); end
        tick();
        n_vec++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL rd_idle: got %0d want 0", dbg_state); end
    endtask

    task automatic test_write_hold();
        m1_addr_i = 32'h24; m1_data_i = 32'h1234; m1_we_i = 1; m1_select_i = 1;
        tick();
        n_vec++; if (s_addr_o !== 32'h24 || s_data_o !== 32'h1234 || s_we_o !== 1) begin n_err++; $display("FAIL wr_req: got %h %h %b want 24 1234 1", s_addr_o, s_data_o, s_we_o); end
        m1_addr_i = 32'hFFFF; m1_data_i = 32'hFFFF; m1_we_i = 0;
        tick(); tick();
        n_vec++; if (s_addr_o !== 32'h24 || s_data_o !== 32'h1234 || s_we_o !== 1 || s_select_o !== 1) begin n_err++; $display("FAIL wr_hold: got %h %h %b %b want 24 1234 1 1", s_addr_o, s_data_o, s_we_o, s_select_o); end
        s_ack_i = 1; s_data_i = 32'h0;
        tick();
        n_vec++; if (m1_ack_o !== 1 || m1_err_o !== 0 || m0_ack_o !== 0) begin n_err++; $display("FAIL wr_ack: got ack1 %b err1 %b ack0 %b want 1 0 0", m1_ack_o, m1_err_o, m0_ack_o); end
        s_ack_i = 0; m1_select_i = 0;
        tick(); tick();
    endtask

    task automatic test_timeout();
        m0_addr_i = 32'h40; m0_we_i = 0; m0_select_i = 1;
        s_data_i = 32'hDEAD;
        tick();
        n_vec++; if (s_select_o !== 1) begin n_err++; $display("FAIL to_sel: got %b want 1", s_select_o); end
        for (int k = 0; k < 7; k++) begin
            tick();
            n_vec++; if (m0_ack_o !== 0 || m0_err_o !== 0) begin n_err++; $display("FAIL to_early[%0d]: got ack %b err %b want 0 0", k, m0_ack_o, m0_err_o); end
        end
        tick();
        n_vec++; if (m0_ack_o !== 1 || m0_err_o !== 1 || m0_data_o !== 32'h0) begin n_err++; $display("FAIL to_fire: got ack %b err %b data %h want 1 1 0", m0_ack_o, m0_err_o, m0_data_o); end
        n_vec++; if (m1_ack_o !== 0 || m1_err_o !== 0 || s_select_o !== 0) begin n_err++; $display("FAIL to_other: got %b %b %b want 0 0 0", m1_ack_o, m1_err_o, s_select_o); end
        m0_select_i = 0;
        m1_addr_i = 32'h50; m1_we_i = 0; m1_select_i = 1;
        tick(); tick();
        n_vec++; if (s_select_o !== 1 || s_addr_o !== 32'h50) begin n_err++; $display("FAIL to_next_req: got sel %b addr %h want 1 50", s_select_o, s_addr_o); end
        s_ack_i = 1; s_data_i = 32'h55;
        tick();
        n_vec++; if (m1_ack_o !== 1 || m1_err_o !== 0 || m1_data_o !== 32'h55 || m0_err_o !== 0) begin n_err++; $display("FAIL to_next_ack: got ack %b err %b data %h err0 %b want 1 0 55 0", m1_ack_o, m1_err_o, m1_data_o, m0_err_o); end
        s_ack_i = 0; m1_select_i = 0;
        tick(); tick();
    endtask

    task automatic test_stale_ack();
        m0_addr_i = 32'h60; m0_we_i = 0; m0_select_i = 1;
        tick();
        s_ack_i = 1; s_data_i = 32'h77;
        tick();
        n_vec++; if (m0_ack_o !== 1 || m0_data_o !== 32'h77) begin n_err++; $display("FAIL st_ack: got ack %b data %h want 1 77", m0_ack_o, m0_data_o); end
        m0_select_i = 0;
        tick();
        n_vec++; if (m0_ack_o !== 0) begin n_err++; $display("FAIL st_done: got ack %b want 0", m0_ack_o); end
        tick();
        n_vec++; if (m0_ack_o !== 0 || dbg_state !== 2'd0) begin n_err++; $display("FAIL st_idle: got ack %b state %0d want 0 0", m0_ack_o, dbg_state); end
        m0_addr_i = 32'h64; m0_select_i = 1;
        tick();
        s_ack_i = 0;
        n_vec++; if (m0_ack_o !== 0 || s_select_o !== 1 || s_addr_o !== 32'h64) begin n_err++; $display("FAIL st_accept: got ack %b sel %b addr %h want 0 1 64", m0_ack_o, s_select_o, s_addr_o); end
        tick();
        n_vec++; if (m0_ack_o !== 0 || s_select_o !== 1) begin n_err++; $display("FAIL st_noack: got ack %b sel %b want 0 1", m0_ack_o, s_select_o); end
        s_ack_i = 1; s_data_i = 32'h88;
        tick();
        n_vec++; if (m0_ack_o !== 1 || m0_data_o !== 32'h88) begin n_err++; $display("FAIL st_real: got ack %b data %h want 1 88", m0_ack_o, m0_data_o); end
        s_ack_i = 0; m0_select_i = 0;
        tick(); tick();
    endtask

    task automatic test_reset_mid();
        m0_addr_i = 32'h70; m0_we_i = 1; m0_select_i = 1;
        tick();
        n_vec++; if (s_select_o !== 1) begin n_err++; $display("FAIL rm_busy: got %b want 1", s_select_o); end
        #2 rst = 1'b0;
        #1;
        n_vec++; if ({s_select_o, s_we_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o} !== 6'b0 || s_addr_o !== 0 || m0_data_o !== 0 || dbg_state !== 2'd0) begin
            n_err++; $display("FAIL rm_async: got sel %b addr %h d0 %h state %0d want all 0", s_select_o, s_addr_o, m0_data_o, dbg_state);
        end
        m0_select_i = 0;
        tick();
        rst = 1'b1;
        tick();
        n_vec++; if (m0_ack_o !== 0 || m1_ack_o !== 0 || s_select_o !== 0) begin n_err++; $display("FAIL rm_noack: got %b %b %b want 0 0 0", m0_ack_o, m1_ack_o, s_select_o); end
        m0_addr_i = 32'h80; m0_we_i = 0; m0_select_i = 1;
        m1_addr_i = 32'h90; m1_we_i = 0; m1_select_i = 1;
        tick();
        n_vec++; if (s_select_o !== 1 || s_addr_o !== 32'h80) begin n_err++; $display("FAIL rm_tie: got sel %b addr %h want 1 80", s_select_o, s_addr_o); end
        s_ack_i = 1; s_data_i = 32'h99;
        tick();
        n_vec++; if (m0_ack_o !== 1 || m1_ack_o !== 0) begin n_err++; $display("FAIL rm_ack: got ack0 %b ack1 %b want 1 0", m0_ack_o, m1_ack_o); end
        s_ack_i = 0; m0_select_i = 0; m1_select_i = 0;
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_read();
        test_write_hold();
        test_timeout();
        test_stale_ack();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
